lcd_text_ctrl: RTL and testbench
================================

# lcd_text_ctrl

Parametrised HD44780-compatible 4-bit character LCD controller: the successor to the fixed 16x2 display path. Runs the power-up/4-bit init sequence on its own after reset, then on request rewrites any subset of 1, 2 or 4 display rows of configurable width from a snapshot of a flat text bus. It sits between application logic producing text and the LCD pins, and owns all LCD bus timing.

## Interface
- COLS, 16: characters per row, 8..20.
- ROWS, 2: number of rows, 1, 2 or 4.
- E_PULSE_CYC, 12: cycles LCD_E is held high per nibble, >=1.
- CMD_WAIT_CYC, 2000: idle cycles after every byte except clear.
- CLEAR_WAIT_CYC, 80000: idle cycles after the clear command (0x01).
- POWERUP_CYC, 2000000: wait from reset release to first init nibble.
- INIT_WAIT_CYC, 205000: idle cycles after each init-only nibble.

- CLK  in  1  clock; all logic on rising edge.
- RESET_N  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  single-cycle refresh request; sampled only while busy=0.
- row_en  in  ROWS  rows to rewrite; bit r selects row r; sampled with start.
- text  in  8*ROWS*COLS  character codes, string order: row r, col c in bits [8*(ROWS*COLS-r*COLS-c)-1 -: 8] (row 0 col 0 is the MSB byte).
- busy  out  1  high during init and during a refresh.
- done  out  1  one-cycle pulse when a refresh completes.
- LCD_D  out  5  bit 4 = RS, bits 3:0 = data nibble.
- LCD_E  out  1  LCD enable strobe.

## Operation
- Reset (RESET_N=0, any time incl. mid-transfer): LCD_D=0, LCD_E=0, busy=1, done=0, all counters cleared, FSM to POWERUP. Release restarts full init; no partial transfer resumes.
- FSM: POWERUP -> INIT_NIB -> INIT_CFG -> IDLE -> (SET_ADDR -> WRITE_CHAR x COLS) per enabled row -> FINISH -> IDLE.
- POWERUP: wait POWERUP_CYC cycles.
- INIT_NIB: RS=0 nibbles 0x3, 0x3, 0x3, 0x2, each followed by INIT_WAIT_CYC.
- INIT_CFG: RS=0 bytes 0x28 (0x20 if ROWS=1), 0x0C, 0x06, 0x01; 0x01 followed by CLEAR_WAIT_CYC, others CMD_WAIT_CYC. Then IDLE, busy=0.
- IDLE: start=1 accepted: text and row_en captured into internal registers, busy=1 next cycle. Later changes on text/row_en have no effect on the running refresh. start while busy=1 ignored (not queued).
- Rows processed ascending r, skipping row_en[r]=0. SET_ADDR: RS=0 byte 0x80|addr, addr row0=0x00, row1=0x40, row2=COLS, row3=0x40+COLS. WRITE_CHAR: RS=1 bytes col 0..COLS-1.
- row_en all zeros: accepted, no LCD activity, done pulses and busy falls the cycle after acceptance.
- FINISH: done=1 and busy=0 in the same cycle; next cycle done=0 and start is accepted.

## Timing
- Nibble: cycle 0 LCD_D driven, LCD_E=0 (setup); cycles 1..E_PULSE_CYC LCD_E=1; cycle E_PULSE_CYC+1 LCD_E=0, LCD_D held (hold). Nibble = E_PULSE_CYC+2 cycles. LCD_D changes only on setup cycles.
- Byte: high nibble then low nibble back-to-back, same RS, then wait cycles with LCD_E=0 and LCD_D held. Byte = 2*(E_PULSE_CYC+2)+wait.
- Refresh latency from start-accept cycle to done: 1 + N_rows*(COLS+1)*(2*(E_PULSE_CYC+2)+CMD_WAIT_CYC) cycles.
- LCD_E never high for other than E_PULSE_CYC consecutive cycles; never high during reset.
- Counters sized for largest parameter; no wrap during any wait.

## Test plan
- Params E_PULSE_CYC=2, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=20, POWERUP_CYC=50, INIT_WAIT_CYC=10, ROWS=2, COLS=16. Reset release -> first LCD_E rise 51 cycles later with LCD_D=0x03; nibble sequence 3,3,3,2,2,8,0,C,0,6,0,1; busy falls after clear wait.
- After init, start with row_en=2'b11, text="HELLO WORLD     "+"0123456789ABCDEF" -> bytes 0x80,'H'..' ',0xC0,'0'..'F', RS=1 on chars only; done exactly 409 cycles after accept.
- row_en=2'b10 -> only 0xC0 + 16 chars sent; done at 205 cycles.
- start during init and during refresh, and text changed mid-refresh -> ignored; transmitted characters match snapshot.
- row_en=0 -> no LCD_E activity; done one cycle after accept.
- RESET_N low mid-character with LCD_E=1 -> LCD_E=0, LCD_D=0, busy=1 immediately; full init reruns after release.

Source files
------------

// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl
// HD44780-compatible character LCD controller driving the display in 4-bit
// mode. After reset it waits for the panel to power up, runs the 4-bit init
// sequence on its own, then on request rewrites any subset of the display rows
// from a snapshot of the flat text bus. All LCD bus timing is owned here.
//
// Ports:
//   CLK      in   clock, everything on the rising edge
//   RESET_N  in   asynchronous active-low reset
//   start    in   one-cycle refresh request, sampled only while idle
//   row_en   in   ROWS  rows to rewrite (bit r = row r), sampled with start
//   text     in   8*ROWS*COLS  characters; row 0 col 0 is the most significant byte
//   busy     out  high during init and during a refresh
//   done     out  one-cycle pulse when a refresh completes
//   LCD_D    out  5    bit 4 = RS, bits 3:0 = data nibble
//   LCD_E    out  LCD enable strobe
module lcd_text_ctrl #(
    parameter int COLS           = 16,
    parameter int ROWS           = 2,
    parameter int E_PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 80000,
    parameter int POWERUP_CYC    = 2000000,
    parameter int INIT_WAIT_CYC  = 205000
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     start,
    input  logic [ROWS-1:0]          row_en,
    input  logic [8*ROWS*COLS-1:0]   text,
    output logic                     busy,
    output logic                     done,
    output logic [4:0]               LCD_D,
    output logic                     LCD_E
);

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared counter serves every wait, so it is sized for the longest one.
    localparam int MAX_CNT = max_i(max_i(max_i(POWERUP_CYC, INIT_WAIT_CYC),
                                         max_i(CLEAR_WAIT_CYC, CMD_WAIT_CYC)),
                                   E_PULSE_CYC);
    localparam int CNT_W = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'((POWERUP_CYC > 0) ? POWERUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] E_LAST    = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'((INIT_WAIT_CYC > 0) ? INIT_WAIT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'((CLEAR_WAIT_CYC > 0) ? CLEAR_WAIT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'((CMD_WAIT_CYC > 0) ? CMD_WAIT_CYC - 1 : 0);
    localparam logic             INIT_ZERO = (INIT_WAIT_CYC == 0);
    localparam logic             CLR_ZERO  = (CLEAR_WAIT_CYC == 0);
    localparam logic             CMD_ZERO  = (CMD_WAIT_CYC == 0);
    localparam logic [4:0]       COL_LAST  = 5'(COLS - 1);

    typedef enum logic [2:0] {
        S_POWERUP, S_INIT_NIB, S_INIT_CFG, S_IDLE, S_SET_ADDR, S_WRITE_CHAR, S_FINISH
    } state_t;

    // Phases of one nibble/byte transfer on the LCD bus.
    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT} phase_t;

    state_t                   state_q, state_d;
    phase_t                   phase_q, phase_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     half_q, half_d;      // 0 = high nibble, 1 = low nibble
    logic [4:0]               step_q, step_d;      // init step or column index
    logic [1:0]               row_q, row_d;
    logic [7:0]               byte_q, byte_d;
    logic                     rs_q, rs_d;
    logic [4:0]               lcd_d_q, lcd_d_d;
    logic                     lcd_e_q, lcd_e_d;
    logic [3:0]               row_en_q, row_en_d;
    logic [8*ROWS*COLS-1:0]   text_q, text_d;

    logic [3:0]               row_en_pad;
    logic [3:0]               rows_above;
    logic [7:0]               chars [4][32];
    logic [4:0]               step_nxt;
    logic                     xfer_active;
    logic                     xfer_end;
    logic [CNT_W-1:0]         wait_last;
    logic                     wait_zero;
    logic                     launch;
    logic                     launch_rs;
    logic [7:0]               launch_byte;
    logic [2:0]               pick;

    // Character lookup from the snapshot, padded to a fixed 4x32 grid so the
    // row/column registers index it at their natural widths.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            if (gi < ROWS) begin : g_en
                assign row_en_pad[gi] = row_en[gi];
            end else begin : g_en_pad
                assign row_en_pad[gi] = 1'b0;
            end
            for (gj = 0; gj < 32; gj++) begin : g_col
                if (gi < ROWS && gj < COLS) begin : g_map
                    assign chars[gi][gj] = text_q[8*(ROWS*COLS - gi*COLS - gj) - 1 -: 8];
                end else begin : g_pad
                    assign chars[gi][gj] = 8'h00;
                end
            end
        end
    endgenerate

    // Lowest set bit of mask as {found, index}.
    function automatic logic [2:0] pick_row(input logic [3:0] mask);
        logic [2:0] res;
        res = 3'b000;
        for (int r = 3; r >= 0; r--) begin
            if (mask[r]) res = {1'b1, 2'(r)};
        end
        return res;
    endfunction

    function automatic logic [7:0] row_addr(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h80;
            2'd1:    return 8'hC0;
            2'd2:    return 8'h80 | 8'(COLS);
            default: return 8'hC0 + 8'(COLS);
        endcase
    endfunction

    function automatic logic [7:0] cfg_byte(input logic [1:0] s);
        case (s)
            2'd0:    return (ROWS == 1) ? 8'h20 : 8'h28;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            rows_above[r] = row_en_q[r] && (2'(r) > row_q);
        end
    end

    assign xfer_active = (state_q == S_INIT_NIB) || (state_q == S_INIT_CFG) ||
                         (state_q == S_SET_ADDR) || (state_q == S_WRITE_CHAR);
    assign step_nxt    = step_q + 5'd1;

    // Only the clear command gets the long wait; init-only nibbles get theirs.
    always_comb begin
        wait_last = CMD_LAST;
        wait_zero = CMD_ZERO;
        if (state_q == S_INIT_NIB) begin
            wait_last = INIT_LAST;
            wait_zero = INIT_ZERO;
        end else if (state_q == S_INIT_CFG && step_q == 5'd3) begin
            wait_last = CLR_LAST;
            wait_zero = CLR_ZERO;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        half_d      = half_q;
        step_d      = step_q;
        row_d       = row_q;
        byte_d      = byte_q;
        rs_d        = rs_q;
        lcd_d_d     = lcd_d_q;
        lcd_e_d     = lcd_e_q;
        row_en_d    = row_en_q;
        text_d      = text_q;
        xfer_end    = 1'b0;
        launch      = 1'b0;
        launch_rs   = 1'b0;
        launch_byte = 8'h00;
        pick        = 3'b000;

        // Transfer engine: setup, E pulse, hold, (low nibble), wait.
        if (xfer_active) begin
            case (phase_q)
                PH_SETUP: begin
                    phase_d = PH_PULSE;
                    cnt_d   = '0;
                    lcd_e_d = 1'b1;
                end
                PH_PULSE: begin
                    if (cnt_q == E_LAST) begin
                        phase_d = PH_HOLD;
                        lcd_e_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PH_HOLD: begin
                    if (!half_q && state_q != S_INIT_NIB) begin
                        phase_d = PH_SETUP;
                        half_d  = 1'b1;
                        lcd_d_d = {rs_q, byte_q[3:0]};
                    end else if (wait_zero) begin
                        xfer_end = 1'b1;
                    end else begin
                        phase_d = PH_WAIT;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    if (cnt_q == wait_last) xfer_end = 1'b1;
                    else                    cnt_d = cnt_q + CNT_W'(1);
                end
            endcase
        end

        // Sequencer: decides what goes out next when a transfer finishes.
        case (state_q)
            S_POWERUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d     = S_INIT_NIB;
                    step_d      = 5'd0;
                    launch      = 1'b1;
                    launch_byte = 8'h30;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_INIT_NIB: begin
                if (xfer_end) begin
                    launch = 1'b1;
                    if (step_q == 5'd3) begin
                        state_d     = S_INIT_CFG;
                        step_d      = 5'd0;
                        launch_byte = cfg_byte(2'd0);
                    end else begin
                        step_d      = step_nxt;
                        launch_byte = (step_q == 5'd2) ? 8'h20 : 8'h30;
                    end
                end
            end
            S_INIT_CFG: begin
                if (xfer_end) begin
                    if (step_q == 5'd3) begin
                        state_d = S_IDLE;
                    end else begin
                        step_d      = step_nxt;
                        launch      = 1'b1;
                        launch_byte = cfg_byte(step_nxt[1:0]);
                    end
                end
            end
            S_IDLE: begin
                if (start) begin
                    text_d   = text;
                    row_en_d = row_en_pad;
                    pick     = pick_row(row_en_pad);
                    if (pick[2]) begin
                        state_d     = S_SET_ADDR;
                        row_d       = pick[1:0];
                        launch      = 1'b1;
                        launch_byte = row_addr(pick[1:0]);
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_SET_ADDR: begin
                if (xfer_end) begin
                    state_d     = S_WRITE_CHAR;
                    step_d      = 5'd0;
                    launch      = 1'b1;
                    launch_rs   = 1'b1;
                    launch_byte = chars[row_q][5'd0];
                end
            end
            S_WRITE_CHAR: begin
                if (xfer_end) begin
                    if (step_q == COL_LAST) begin
                        pick = pick_row(rows_above);
                        if (pick[2]) begin
                            state_d     = S_SET_ADDR;
                            row_d       = pick[1:0];
                            launch      = 1'b1;
                            launch_byte = row_addr(pick[1:0]);
                        end else begin
                            state_d = S_FINISH;
                        end
                    end else begin
                        step_d      = step_nxt;
                        launch      = 1'b1;
                        launch_rs   = 1'b1;
                        launch_byte = chars[row_q][step_nxt];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new transfer always begins with its high-nibble setup cycle.
        if (launch) begin
            phase_d = PH_SETUP;
            half_d  = 1'b0;
            cnt_d   = '0;
            rs_d    = launch_rs;
            byte_d  = launch_byte;
            lcd_d_d = {launch_rs, launch_byte[7:4]};
            lcd_e_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_POWERUP;
            phase_q  <= PH_SETUP;
            cnt_q    <= '0;
            half_q   <= 1'b0;
            step_q   <= '0;
            row_q    <= '0;
            byte_q   <= '0;
            rs_q     <= 1'b0;
            lcd_d_q  <= '0;
            lcd_e_q  <= 1'b0;
            row_en_q <= '0;
            text_q   <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            step_q   <= step_d;
            row_q    <= row_d;
            byte_q   <= byte_d;
            rs_q     <= rs_d;
            lcd_d_q  <= lcd_d_d;
            lcd_e_q  <= lcd_e_d;
            row_en_q <= row_en_d;
            text_q   <= text_d;
        end
    end

    assign busy  = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done  = (state_q == S_FINISH);
    assign LCD_D = lcd_d_q;
    assign LCD_E = lcd_e_q;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed testbench for lcd_text_ctrl with short timing parameters.
module tb_lcd_text_ctrl;

    localparam int COLS  = 16;
    localparam int ROWS  = 2;
    localparam int EPW   = 2;
    localparam int TW    = 8 * ROWS * COLS;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b0;
    logic            start  = 1'b0;
    logic [ROWS-1:0] row_en = '0;
    logic [TW-1:0]   text   = '0;
    logic            busy;
    logic            done;
    logic [4:0]      lcd_d;
    logic            lcd_e;

    int checks = 0;
    int errors = 0;

    logic [4:0] nibs [$];
    int         e_rises = 0;
    bit         prev_e  = 1'b0;
    int         run_len = 0;
    logic [4:0] d_at_rise = '0;

    lcd_text_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .E_PULSE_CYC(EPW), .CMD_WAIT_CYC(4),
        .CLEAR_WAIT_CYC(20), .POWERUP_CYC(50), .INIT_WAIT_CYC(10)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .start(start), .row_en(row_en), .text(text),
        .busy(busy), .done(done), .LCD_D(lcd_d), .LCD_E(lcd_e)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: records each nibble strobed, checks pulse width and hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("e_low_in_reset", 32'(lcd_e), 32'd0);
            prev_e  = 1'b0;
            run_len = 0;
        end else begin
            if (lcd_e) begin
                if (!prev_e) begin
                    nibs.push_back(lcd_d);
                    e_rises++;
                    d_at_rise = lcd_d;
                end
                run_len++;
            end else if (prev_e) begin
                check("e_pulse_width", 32'(run_len), 32'(EPW));
                check("d_hold", 32'(lcd_d), 32'(d_at_rise));
                run_len = 0;
            end
            prev_e = lcd_e;
        end
    end

    // Holds reset, checks reset outputs, releases, and checks the init sequence.
    task automatic init_check(input string tag);
        logic [4:0] exp_nib [12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                                     5'h00, 5'h0C, 5'h00, 5'h06, 5'h00, 5'h01};
        int n;
        int rise_at;
        repeat (3) @(negedge clk);
        check({tag, "_rst_busy"}, 32'(busy), 32'd1);
        check({tag, "_rst_done"}, 32'(done), 32'd0);
        check({tag, "_rst_e"}, 32'(lcd_e), 32'd0);
        check({tag, "_rst_d"}, 32'(lcd_d), 32'd0);
        nibs.delete();
        rst_n   = 1'b1;
        n       = 0;
        rise_at = -1;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            start = (n == 100);     // request during init must be ignored
            row_en = 2'b11;
            if (lcd_e && rise_at < 0) begin
                rise_at = n;
                check({tag, "_first_d"}, 32'(lcd_d), 32'h03);
            end
            if (!busy) break;
        end
        start = 1'b0;
        check({tag, "_first_rise"}, 32'(rise_at), 32'd51);
        check({tag, "_busy_fall"}, 32'(n), 32'd170);
        check({tag, "_nib_count"}, 32'(nibs.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("%s_nib%0d", tag, i),
                  (i < nibs.size()) ? 32'(nibs[i]) : 32'hFFFF, 32'(exp_nib[i]));
        end
        repeat (5) @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_no_extra"}, 32'(nibs.size()), 32'd12);
    endtask

    task automatic refresh(input string tag, input logic [ROWS-1:0] en,
                           input logic [TW-1:0] txt, input int exp_lat, input bit disturb);
        logic [8:0] exp_b [$];
        logic [9:0] got;
        int n;
        int rises0;
        for (int r = 0; r < ROWS; r++) begin
            if (en[r]) begin
                exp_b.push_back({1'b0, (r == 0) ? 8'h80 : 8'hC0});
                for (int c = 0; c < COLS; c++) begin
                    exp_b.push_back({1'b1, txt[8*(ROWS*COLS - r*COLS - c) - 1 -: 8]});
                end
            end
        end
        @(negedge clk);
        nibs.delete();
        rises0 = e_rises;
        start  = 1'b1;
        row_en = en;
        text   = txt;
        n      = 0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (n == 1) check({tag, "_busy_after_accept"}, 32'(busy), (en != 0) ? 32'd1 : 32'd0);
            if (disturb && n == 30) begin
                text   = ~txt;
                row_en = ~en;
                start  = 1'b1;      // ignored while busy
            end
            if (done) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_nib_count"}, 32'(nibs.size()), 32'(2 * exp_b.size()));
        if (en == 0) check({tag, "_no_e"}, 32'(e_rises - rises0), 32'd0);
        for (int i = 0; i < exp_b.size(); i++) begin
            if (2*i + 1 < nibs.size())
                got = {nibs[2*i+1][4], nibs[2*i][4], nibs[2*i][3:0], nibs[2*i+1][3:0]};
            else
                got = 10'h3FF;
            check($sformatf("%s_byte%0d", tag, i), 32'(got), 32'({exp_b[i][8], exp_b[i]}));
        end
    endtask

    initial begin
        logic [TW-1:0] t1;
        logic [TW-1:0] t2;
        logic [TW-1:0] t3;
        int k;
        t1 = {"HELLO WORLD     ", "0123456789ABCDEF"};
        t2 = {"abcdefghijklmnop", "Row two text 123"};
        t3 = {"Reset survived! ", "xxxxxxxxxxxxxxxx"};

        init_check("init1");
        refresh("both_rows", 2'b11, t1, 409, 1'b1);
        refresh("row1_only", 2'b10, t2, 205, 1'b0);
        refresh("no_rows", 2'b00, t2, 1, 1'b0);

        // Reset in the middle of a character strobe.
        @(negedge clk);
        start  = 1'b1;
        row_en = 2'b11;
        text   = t1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        k = 0;
        while (!lcd_e && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("mid_e_high", 32'(lcd_e), 32'd1);
        check("mid_rs_char", 32'(lcd_d[4]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_e", 32'(lcd_e), 32'd0);
        check("mid_rst_d", 32'(lcd_d), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        init_check("init2");
        refresh("after_reinit", 2'b01, t3, 205, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
